amt_repair_ctrl: RTL and testbench

AMT_REPAIR_CTRL -- requirements
Module: amt_repair_ctrl

---
 rtl/amt_repair_ctrl.sv | 120 ++++++++++++
 tb/tb_amt_repair_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amt_repair_ctrl.sv
// Walks the AMT N_PACKETS entries per cycle and copies each entry into the RMT,
// with the write trailing the AMT read by one registered pipeline stage.
module amt_repair_ctrl #(
  parameter int DEPTH     = 16,
  parameter int INDEX     = 4,
  parameter int WIDTH     = 8,
  parameter int N_PACKETS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                repairStart_i,
  input  logic                                amtReady_i,
  output logic                                repairFlag_o,
  output logic [N_PACKETS-1:0][INDEX-1:0]     repairAddr_o,
  input  logic [N_PACKETS-1:0][WIDTH-1:0]     repairData_i,
  output logic [N_PACKETS-1:0]                rmtWrEn_o,
  output logic [N_PACKETS-1:0][INDEX-1:0]     rmtWrAddr_o,
  output logic [N_PACKETS-1:0][WIDTH-1:0]     rmtWrData_o,
  output logic                                repairBusy_o,
  output logic                                repairDone_o
);

  // Wide enough that base + lane index and base + N_PACKETS never wrap.
  localparam int AW = INDEX + 1 + $clog2(N_PACKETS + 1);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
  localparam logic [AW-1:0] NPKT_W  = AW'(N_PACKETS);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                          state_reg;
  logic [AW-1:0]                   base_reg;
  logic                            pending_reg;

  logic [AW-1:0]                   base_step;
  logic [AW-1:0]                   issue_base;
  logic                            last_packet;
  logic                            start_go;
  logic [N_PACKETS-1:0]            cur_valid;
  logic [N_PACKETS-1:0][INDEX-1:0] cur_addr;
  logic [N_PACKETS-1:0][INDEX-1:0] next_addr;

  assign base_step   = base_reg + NPKT_W;
  assign last_packet = (base_step >= DEPTH_W);
  // Base of the packet whose addresses are presented in the following cycle.
  assign issue_base  = (state_reg == IDLE) ? '0 : base_step;
  assign start_go    = (repairStart_i | pending_reg) & amtReady_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_PACKETS; gi++) begin : g_lane
      logic [AW-1:0] cur_sum;
      logic [AW-1:0] next_sum;
      assign cur_sum        = base_reg + AW'(gi);
      assign next_sum       = issue_base + AW'(gi);
      assign cur_valid[gi]  = (cur_sum < DEPTH_W);
      assign cur_addr[gi]   = cur_valid[gi] ? cur_sum[INDEX-1:0] : '0;
      assign next_addr[gi]  = (next_sum < DEPTH_W) ? next_sum[INDEX-1:0] : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      base_reg     <= '0;
      pending_reg  <= 1'b0;
      repairFlag_o <= 1'b0;
      repairAddr_o <= '0;
      rmtWrEn_o    <= '0;
      rmtWrAddr_o  <= '0;
      rmtWrData_o  <= '0;
      repairBusy_o <= 1'b0;
      repairDone_o <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rmtWrEn_o    <= '0;
          rmtWrAddr_o  <= '0;
          rmtWrData_o  <= '0;
          repairDone_o <= 1'b0;
          if (start_go) begin
            state_reg    <= ISSUE;
            base_reg     <= '0;
            pending_reg  <= 1'b0;
            repairFlag_o <= 1'b1;
            repairBusy_o <= 1'b1;
            repairAddr_o <= next_addr;
          end else if (repairStart_i) begin
            pending_reg <= 1'b1;
          end
        end
        ISSUE: begin
          rmtWrEn_o   <= cur_valid;
          rmtWrAddr_o <= cur_addr;
          for (int i = 0; i < N_PACKETS; i++)
            rmtWrData_o[i] <= cur_valid[i] ? repairData_i[i] : '0;
          if (last_packet) begin
            state_reg    <= DRAIN;
            repairFlag_o <= 1'b0;
            repairAddr_o <= '0;
            repairDone_o <= 1'b1;
          end else begin
            base_reg     <= base_step;
            repairAddr_o <= next_addr;
          end
        end
        DRAIN: begin
          state_reg    <= IDLE;
          base_reg     <= '0;
          repairBusy_o <= 1'b0;
          repairDone_o <= 1'b0;
          rmtWrEn_o    <= '0;
          rmtWrAddr_o  <= '0;
          rmtWrData_o  <= '0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amt_repair_ctrl.sv
// Bench for amt_repair_ctrl: three configurations share one stimulus stream;
// expected RMT writes are queued per configuration and consumed by negedge monitors.
module tb_amt_repair_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // a: defaults
  logic            flag_a, busy_a, done_a;
  logic [7:0][3:0] addr_a, waddr_a;
  logic [7:0][7:0] rdata_a, wdata_a;
  logic [7:0]      wen_a;
  // b: DEPTH=20, INDEX=5
  logic            flag_b, busy_b, done_b;
  logic [7:0][4:0] addr_b, waddr_b;
  logic [7:0][7:0] rdata_b, wdata_b;
  logic [7:0]      wen_b;
  // c: N_PACKETS=32, DEPTH=16
  logic             flag_c, busy_c, done_c;
  logic [31:0][3:0] addr_c, waddr_c;
  logic [31:0][7:0] rdata_c, wdata_c;
  logic [31:0]      wen_c;

  amt_repair_ctrl u_dut_a (
    .clk(clk), .reset(reset), .repairStart_i(start), .amtReady_i(ready),
    .repairFlag_o(flag_a), .repairAddr_o(addr_a), .repairData_i(rdata_a),
    .rmtWrEn_o(wen_a), .rmtWrAddr_o(waddr_a), .rmtWrData_o(wdata_a),
    .repairBusy_o(busy_a), .repairDone_o(done_a));

  amt_repair_ctrl #(.DEPTH(20), .INDEX(5), .WIDTH(8), .N_PACKETS(8)) u_dut_b (
    .clk(clk), .reset(reset), .repairStart_i(start), .amtReady_i(ready),
    .repairFlag_o(flag_b), .repairAddr_o(addr_b), .repairData_i(rdata_b),
    .rmtWrEn_o(wen_b), .rmtWrAddr_o(waddr_b), .rmtWrData_o(wdata_b),
    .repairBusy_o(busy_b), .repairDone_o(done_b));

  amt_repair_ctrl #(.DEPTH(16), .INDEX(4), .WIDTH(8), .N_PACKETS(32)) u_dut_c (
    .clk(clk), .reset(reset), .repairStart_i(start), .amtReady_i(ready),
    .repairFlag_o(flag_c), .repairAddr_o(addr_c), .repairData_i(rdata_c),
    .rmtWrEn_o(wen_c), .rmtWrAddr_o(waddr_c), .rmtWrData_o(wdata_c),
    .repairBusy_o(busy_c), .repairDone_o(done_c));

  // AMT model: entry k holds k+32, read combinationally.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    rdata_c = '0;
    for (int i = 0; i < 8; i++) rdata_a[i] = 8'(addr_a[i]) + 8'd32;
    for (int i = 0; i < 8; i++) rdata_b[i] = 8'(addr_b[i]) + 8'd32;
    for (int i = 0; i < 32; i++) rdata_c[i] = 8'(addr_c[i]) + 8'd32;
  end

  logic [31:0] qa_addr[$], qa_data[$];
  logic [31:0] qb_addr[$], qb_data[$];
  logic [31:0] qc_addr[$], qc_data[$];

  always @(negedge clk) begin
    logic [31:0] ea, ed;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wen_a[i] === 1'b1) begin
        if (qa_addr.size() == 0) begin
          errors++;
          $display("FAIL sb_a unexpected write lane %0d: got addr=%0d data=%0d, want no write", i, waddr_a[i], wdata_a[i]);
        end else begin
          ea = qa_addr.pop_front(); ed = qa_data.pop_front();
          if (32'(waddr_a[i]) !== ea || 32'(wdata_a[i]) !== ed) begin
            errors++;
            $display("FAIL sb_a lane %0d: got addr=%0d data=%0d, want addr=%0d data=%0d", i, waddr_a[i], wdata_a[i], ea, ed);
          end
        end
      end else if (wen_a[i] !== 1'b0 || waddr_a[i] !== 4'd0 || wdata_a[i] !== 8'd0) begin
        errors++;
        $display("FAIL sb_a idle lane %0d: got en=%b addr=%0d data=%0d, want 0/0/0", i, wen_a[i], waddr_a[i], wdata_a[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wen_b[i] === 1'b1) begin
        if (qb_addr.size() == 0) begin
          errors++;
          $display("FAIL sb_b unexpected write lane %0d: got addr=%0d data=%0d, want no write", i, waddr_b[i], wdata_b[i]);
        end else begin
          ea = qb_addr.pop_front(); ed = qb_data.pop_front();
          if (32'(waddr_b[i]) !== ea || 32'(wdata_b[i]) !== ed) begin
            errors++;
            $display("FAIL sb_b lane %0d: got addr=%0d data=%0d, want addr=%0d data=%0d", i, waddr_b[i], wdata_b[i], ea, ed);
          end
        end
      end else if (wen_b[i] !== 1'b0 || waddr_b[i] !== 5'd0 || wdata_b[i] !== 8'd0) begin
        errors++;
        $display("FAIL sb_b idle lane %0d: got en=%b addr=%0d data=%0d, want 0/0/0", i, wen_b[i], waddr_b[i], wdata_b[i]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (wen_c[i] === 1'b1) begin
        if (qc_addr.size() == 0) begin
          errors++;
          $display("FAIL sb_c unexpected write lane %0d: got addr=%0d data=%0d, want no write", i, waddr_c[i], wdata_c[i]);
        end else begin
          ea = qc_addr.pop_front(); ed = qc_data.pop_front();
          if (32'(waddr_c[i]) !== ea || 32'(wdata_c[i]) !== ed) begin
            errors++;
            $display("FAIL sb_c lane %0d: got addr=%0d data=%0d, want addr=%0d data=%0d", i, waddr_c[i], wdata_c[i], ea, ed);
          end
        end
      end else if (wen_c[i] !== 1'b0 || waddr_c[i] !== 4'd0 || wdata_c[i] !== 8'd0) begin
        errors++;
        $display("FAIL sb_c idle lane %0d: got en=%b addr=%0d data=%0d, want 0/0/0", i, wen_c[i], waddr_c[i], wdata_c[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int na, input int nb, input int nc);
    for (int k = 0; k < na; k++) begin qa_addr.push_back(32'(k)); qa_data.push_back(32'(k + 32)); end
    for (int k = 0; k < nb; k++) begin qb_addr.push_back(32'(k)); qb_data.push_back(32'(k + 32)); end
    for (int k = 0; k < nc; k++) begin qc_addr.push_back(32'(k)); qc_data.push_back(32'(k + 32)); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({flag_a, busy_a, done_a, wen_a, flag_b, busy_b, done_b, wen_b, flag_c, busy_c, done_c, wen_c} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b%b%b en_a=%h en_b=%h en_c=%h, want all 0", busy_a, busy_b, busy_c, wen_a, wen_b, wen_c);
    end
    checks++;
    if ({addr_a, addr_b, addr_c} !== '0) begin
      errors++;
      $display("FAIL reset_addr: got a=%h b=%h c=%h, want 0", addr_a, addr_b, addr_c);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      errors++;
      $display("FAIL reset_priority: got busy=%b%b%b, want 000", busy_a, busy_b, busy_c);
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_basic();
    logic [2:0] ex_a, ex_b, ex_c;
    logic [7:0][3:0] ea;
    logic [7:0][4:0] eb;
    logic [31:0][3:0] ec;
    push_exp(16, 20, 16);
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      ex_a = {(c <= 2), (c <= 3), (c == 3)};
      ex_b = {(c <= 3), (c <= 4), (c == 4)};
      ex_c = {(c == 1), (c <= 2), (c == 2)};
      checks++;
      if ({flag_a, busy_a, done_a} !== ex_a) begin
        errors++;
        $display("FAIL basic_fsm_a c%0d: got flag/busy/done=%b, want %b", c, {flag_a, busy_a, done_a}, ex_a);
      end
      checks++;
      if ({flag_b, busy_b, done_b} !== ex_b) begin
        errors++;
        $display("FAIL basic_fsm_b c%0d: got flag/busy/done=%b, want %b", c, {flag_b, busy_b, done_b}, ex_b);
      end
      checks++;
      if ({flag_c, busy_c, done_c} !== ex_c) begin
        errors++;
        $display("FAIL basic_fsm_c c%0d: got flag/busy/done=%b, want %b", c, {flag_c, busy_c, done_c}, ex_c);
      end
      if (c <= 2) begin
        for (int i = 0; i < 8; i++) ea[i] = 4'((c - 1) * 8 + i);
        checks++;
        if (addr_a !== ea) begin
          errors++;
          $display("FAIL basic_addr_a c%0d: got %h, want %h", c, addr_a, ea);
        end
      end
      if (c == 3) begin
        for (int i = 0; i < 8; i++) eb[i] = (i < 4) ? 5'(16 + i) : 5'd0;
        checks++;
        if (addr_b !== eb) begin
          errors++;
          $display("FAIL basic_addr_b_tail: got %h, want %h", addr_b, eb);
        end
      end
      if (c == 1) begin
        for (int i = 0; i < 32; i++) ec[i] = (i < 16) ? 4'(i) : 4'd0;
        checks++;
        if (addr_c !== ec) begin
          errors++;
          $display("FAIL basic_addr_c: got %h, want %h", addr_c, ec);
        end
      end
      checks++;
      if (wen_a !== ((c == 2 || c == 3) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL basic_wen_a c%0d: got %h", c, wen_a);
      end
      if (c == 4) begin
        checks++;
        if (wen_b !== 8'h0F) begin
          errors++;
          $display("FAIL basic_wen_b_tail: got %h, want 0f", wen_b);
        end
      end
      if (c == 2) begin
        checks++;
        if (wen_c !== 32'h0000FFFF) begin
          errors++;
          $display("FAIL basic_wen_c: got %h, want 0000ffff", wen_c);
        end
      end
      tick();
    end
    checks++;
    if (qa_addr.size() + qb_addr.size() + qc_addr.size() != 0) begin
      errors++;
      $display("FAIL basic_drain: got %0d/%0d/%0d writes missing, want 0", qa_addr.size(), qb_addr.size(), qc_addr.size());
    end
    $display("test_basic done: errors=%0d", errors);
  endtask

  task automatic test_wait_ready();
    push_exp(16, 20, 16);
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if ({busy_a, busy_b, busy_c, flag_a} !== 4'b0000) begin
        errors++;
        $display("FAIL wait_ready_idle c%0d: got busy=%b%b%b flag=%b, want 0", c, busy_a, busy_b, busy_c, flag_a);
      end
      if (c == 5) ready = 1'b1;
      tick();
    end
    checks++;
    if ({flag_a, busy_a, addr_a[0], flag_b, flag_c} !== {1'b1, 1'b1, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL wait_ready_issue: got flag=%b%b%b busy_a=%b addr0=%0d, want 111 1 0", flag_a, flag_b, flag_c, busy_a, addr_a[0]);
    end
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (qa_addr.size() + qb_addr.size() + qc_addr.size() != 0) begin
      errors++;
      $display("FAIL wait_ready_drain: got %0d/%0d/%0d writes missing, want 0", qa_addr.size(), qb_addr.size(), qc_addr.size());
    end
    $display("test_wait_ready done: errors=%0d", errors);
  endtask

  task automatic test_restart_ignored();
    int dn_a = 0, dn_b = 0, dn_c = 0, fl_a = 0, fl_b = 0, fl_c = 0;
    push_exp(16, 20, 16);
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      dn_a += int'(done_a); dn_b += int'(done_b); dn_c += int'(done_c);
      fl_a += int'(flag_a); fl_b += int'(flag_b); fl_c += int'(flag_c);
      if (c == 1) begin start = 1'b1; ready = 1'b0; end
      if (c == 2) start = 1'b0;
      if (c == 5) ready = 1'b1;
      tick();
    end
    checks++;
    if (dn_a != 1 || dn_b != 1 || dn_c != 1) begin
      errors++;
      $display("FAIL restart_done_count: got %0d/%0d/%0d, want 1/1/1", dn_a, dn_b, dn_c);
    end
    checks++;
    if (fl_a != 2 || fl_b != 3 || fl_c != 1) begin
      errors++;
      $display("FAIL restart_issue_cycles: got %0d/%0d/%0d, want 2/3/1", fl_a, fl_b, fl_c);
    end
    checks++;
    if (qa_addr.size() + qb_addr.size() + qc_addr.size() != 0) begin
      errors++;
      $display("FAIL restart_drain: got %0d/%0d/%0d writes missing, want 0", qa_addr.size(), qb_addr.size(), qc_addr.size());
    end
    $display("test_restart_ignored done: errors=%0d", errors);
  endtask

  task automatic test_reset_abort();
    int dn_a = 0;
    push_exp(8, 8, 16);
    ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({flag_a, busy_a, done_a, wen_a, addr_a, waddr_a, wdata_a} !== '0) begin
      errors++;
      $display("FAIL abort_outputs_a: got flag=%b busy=%b done=%b en=%h addr=%h, want 0", flag_a, busy_a, done_a, wen_a, addr_a);
    end
    checks++;
    if ({flag_b, busy_b, done_b, wen_b, addr_b, waddr_b, wdata_b} !== '0) begin
      errors++;
      $display("FAIL abort_outputs_b: got flag=%b busy=%b done=%b en=%h addr=%h, want 0", flag_b, busy_b, done_b, wen_b, addr_b);
    end
    for (int c = 0; c < 5; c++) begin
      dn_a += int'(done_a) + int'(busy_a);
      tick();
    end
    checks++;
    if (dn_a != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, want 0", dn_a);
    end
    push_exp(16, 20, 16);
    start = 1'b1;
    tick();
    start = 1'b0;
    dn_a = 0;
    for (int c = 1; c <= 6; c++) begin
      dn_a += int'(done_a);
      tick();
    end
    checks++;
    if (dn_a != 1) begin
      errors++;
      $display("FAIL abort_rerun_done: got %0d, want 1", dn_a);
    end
    checks++;
    if (qa_addr.size() + qb_addr.size() + qc_addr.size() != 0) begin
      errors++;
      $display("FAIL abort_drain: got %0d/%0d/%0d writes missing, want 0", qa_addr.size(), qb_addr.size(), qc_addr.size());
    end
    $display("test_reset_abort done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_ready();
    test_restart_ignored();
    test_reset_abort();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
